// File: rtl/midi_tx_serializer.sv
// midi_tx_serializer
//   Pops bytes from the upstream output FIFO and sends each one on `tx` as an
//   8-N-1 MIDI frame: a start bit (0), the data bits LSB first, then a stop
//   bit (1). The line idles high. The block drives the FIFO pop handshake
//   (`rd` / `oe_n`) itself.
//
// Parameters
//   WIDTH        data byte width; must match the FIFO width
//   CLKS_PER_BIT clk cycles per serial bit (>=1)
//   RD_LATENCY   cycles from the rd pulse to valid data_i (>=1)
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset
//   tx_en    in   1 allows a new frame to start
//   empty_n  in   FIFO has at least one byte
//   data_i   in   FIFO read data
//   rd       out  one-cycle FIFO pop strobe (REQ only)
//   oe_n     out  FIFO output enable, active low (REQ and WAIT)
//   tx       out  serial MIDI line, idle high
//   busy     out  high in every state except IDLE
//   tx_done  out  one-cycle pulse after a stop bit completes
module midi_tx_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int RD_LATENCY   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             empty_n,
  input  logic [WIDTH-1:0] data_i,
  output logic             rd,
  output logic             oe_n,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  // The +1 keeps every counter at least one bit wide when its limit is 1.
  localparam int TMR_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam int WAIT_W = $clog2(RD_LATENCY) + 1;
  localparam int CNT_W  = $clog2(WIDTH) + 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  bit_tmr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  shift;

  logic bit_end;
  logic wait_end;
  logic start_ok;

  assign bit_end  = (bit_tmr == TMR_LAST);
  assign wait_end = (wait_cnt == WAIT_LAST);
  assign start_ok = tx_en & empty_n;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (wait_end) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = S_STOP;
      S_STOP: begin
        // empty_n and tx_en are only consulted here and in IDLE, so changes
        // during a frame never alter the frame in flight.
        if (bit_end) state_nxt = start_ok ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timers, bit counter, shift register and the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_tmr  <= '0;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= (state == S_STOP) && bit_end;

      // Bit timer only runs while a bit is on the line; it restarts on every
      // state change and at each bit boundary inside DATA.
      if (state != state_nxt || bit_end) begin
        bit_tmr <= '0;
      end else if (state == S_START || state == S_DATA || state == S_STOP) begin
        bit_tmr <= bit_tmr + 1'b1;
      end else begin
        bit_tmr <= '0;
      end

      if (state == S_WAIT && !wait_end) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state != S_DATA) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end

      // Capture on the last WAIT edge, the same edge that enters START.
      if (state == S_WAIT && wait_end) begin
        shift <= data_i;
      end else if (state == S_DATA && bit_end) begin
        shift <= shift >> 1;
      end
    end
  end

  // Output decode, purely from registered state
  always_comb begin
    tx   = 1'b1;
    rd   = 1'b0;
    oe_n = 1'b1;
    busy = 1'b1;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_REQ: begin
        rd   = 1'b1;
        oe_n = 1'b0;
      end
      S_WAIT:  oe_n = 1'b0;
      S_START: tx = 1'b0;
      S_DATA:  tx = shift[0];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_midi_tx_serializer.sv
// Testbench for midi_tx_serializer. Two instances: A (4 clocks/bit, read
// latency 1) and B (1 clock/bit, read latency 2). Each has a FIFO model and
// a frame monitor that pops the expected byte from a scoreboard queue when a
// start bit appears and compares every line cycle of the frame.
module tb_midi_tx_serializer;

  localparam int A_CPB = 4;
  localparam int A_RDL = 1;
  localparam int B_CPB = 1;
  localparam int B_RDL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_tx_en = 1'b0, a_empty_n = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_rd, a_oe_n, a_tx, a_busy, a_tx_done;

  logic       b_tx_en = 1'b0, b_empty_n = 1'b0;
  logic [7:0] b_data = 8'h00, b_s0 = 8'h00;
  logic       b_rd, b_oe_n, b_tx, b_busy, b_tx_done;

  midi_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(A_CPB), .RD_LATENCY(A_RDL)) u_a (
    .clk(clk), .reset(reset), .tx_en(a_tx_en), .empty_n(a_empty_n), .data_i(a_data),
    .rd(a_rd), .oe_n(a_oe_n), .tx(a_tx), .busy(a_busy), .tx_done(a_tx_done)
  );

  midi_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(B_CPB), .RD_LATENCY(B_RDL)) u_b (
    .clk(clk), .reset(reset), .tx_en(b_tx_en), .empty_n(b_empty_n), .data_i(b_data),
    .rd(b_rd), .oe_n(b_oe_n), .tx(b_tx), .busy(b_busy), .tx_done(b_tx_done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level at cycle c of a frame (c=0 is the first start cycle).
  function automatic logic exp_tx(input int c, input logic [7:0] b, input int cpb);
    if (c < cpb) return 1'b0;
    if (c < 9 * cpb) return b[(c - cpb) / cpb];
    return 1'b1;
  endfunction

  // FIFO models and scoreboards
  logic [7:0] a_fifo[$], a_exp[$], b_fifo[$], b_exp[$];
  int a_uflow = 0, b_uflow = 0;

  always @(posedge clk) begin
    if (a_rd) begin
      if (a_fifo.size() == 0) a_uflow <= a_uflow + 1;
      else a_data <= a_fifo.pop_front();
    end
  end

  always @(posedge clk) begin
    if (b_rd) begin
      if (b_fifo.size() == 0) b_uflow <= b_uflow + 1;
      else b_s0 <= b_fifo.pop_front();
    end
    b_data <= b_s0;
  end

  always @(negedge clk) begin
    a_empty_n = (a_fifo.size() != 0);
    b_empty_n = (b_fifo.size() != 0);
  end

  // Frame monitors
  int a_cyc = 0, a_rd_cyc = 0, a_rd_cnt = 0, a_done_cnt = 0, a_frames = 0, a_mcnt = 0, a_gap = 0;
  bit a_mact = 0;
  logic [7:0] a_mexp = 8'h00;
  int a_gaps[$];

  always @(negedge clk) begin
    a_cyc++;
    if (reset) begin
      a_mact = 0;
    end else begin
      if (a_rd) begin
        a_rd_cyc = a_cyc;
        a_rd_cnt++;
      end
      if (a_tx_done) a_done_cnt++;
      if (!a_mact) begin
        if (a_tx == 1'b0) begin
          a_mact = 1;
          a_mcnt = 0;
          if (a_exp.size() == 0) begin
            chk("a_unexpected_frame", 1, 0);
            a_mexp = 8'h00;
          end else begin
            a_mexp = a_exp.pop_front();
          end
          chk("a_rd_to_start", a_cyc - a_rd_cyc, 1 + A_RDL);
          a_gaps.push_back(a_gap);
        end else begin
          a_gap++;
        end
      end
      if (a_mact) begin
        if (a_mcnt < 10 * A_CPB) begin
          chk($sformatf("a_tx_%02h_c%0d", a_mexp, a_mcnt), a_tx, exp_tx(a_mcnt, a_mexp, A_CPB));
        end else begin
          chk("a_tx_done_at_end", a_tx_done, 1);
          a_mact = 0;
          a_gap  = 1;
          a_frames++;
        end
        a_mcnt++;
      end
    end
  end

  int b_cyc = 0, b_rd_cyc = 0, b_rd_cnt = 0, b_done_cnt = 0, b_frames = 0, b_mcnt = 0;
  bit b_mact = 0;
  logic [7:0] b_mexp = 8'h00;

  always @(negedge clk) begin
    b_cyc++;
    if (reset) begin
      b_mact = 0;
    end else begin
      if (b_rd) begin
        b_rd_cyc = b_cyc;
        b_rd_cnt++;
      end
      if (b_tx_done) b_done_cnt++;
      if (!b_mact && b_tx == 1'b0) begin
        b_mact = 1;
        b_mcnt = 0;
        if (b_exp.size() == 0) begin
          chk("b_unexpected_frame", 1, 0);
          b_mexp = 8'h00;
        end else begin
          b_mexp = b_exp.pop_front();
        end
        chk("b_rd_to_start", b_cyc - b_rd_cyc, 1 + B_RDL);
      end
      if (b_mact) begin
        if (b_mcnt < 10 * B_CPB) begin
          chk($sformatf("b_tx_%02h_c%0d", b_mexp, b_mcnt), b_tx, exp_tx(b_mcnt, b_mexp, B_CPB));
        end else begin
          chk("b_tx_done_at_end", b_tx_done, 1);
          b_mact = 0;
          b_frames++;
        end
        b_mcnt++;
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b);
    a_fifo.push_back(b);
    a_exp.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    b_fifo.push_back(b);
    b_exp.push_back(b);
  endtask

  task automatic wait_a_done(input int n);
    int t = 0;
    while (a_done_cnt < n && t < 2000) begin
      step();
      t++;
    end
    chk("a_done_in_time", (a_done_cnt >= n), 1);
  endtask

  task automatic wait_b_done(input int n);
    int t = 0;
    while (b_done_cnt < n && t < 2000) begin
      step();
      t++;
    end
    chk("b_done_in_time", (b_done_cnt >= n), 1);
  endtask

  task automatic wait_a_cnt(input int c);
    int t = 0;
    while (!(a_mact && a_mcnt == c) && t < 1000) begin
      step();
      t++;
    end
    chk("a_reach_cycle", (a_mact && a_mcnt == c), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int t;
    int done_seen;
    int rd_base;
    int g_base;

    // Reset values
    reset = 1'b1;
    repeat (3) step();
    chk("rst_a_tx", a_tx, 1);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_oe_n", a_oe_n, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_tx_done", a_tx_done, 0);
    chk("rst_b_tx", b_tx, 1);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_oe_n", b_oe_n, 1);
    reset = 1'b0;

    // Idle with an empty FIFO
    a_tx_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (a_tx !== 1'b1 || a_rd !== 1'b0 || a_oe_n !== 1'b1 || a_busy !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);
    chk("idle_rd_count", a_rd_cnt, 0);

    // Single byte
    push_a(8'h90);
    wait_a_done(1);
    step();
    chk("single_rd_count", a_rd_cnt, 1);
    chk("single_frames", a_frames, 1);
    chk("single_busy_after", a_busy, 0);

    // Back-to-back bytes
    g_base = a_gaps.size();
    push_a(8'h90);
    push_a(8'h3C);
    push_a(8'h7F);
    t = 0;
    while (a_rd !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    chk("b2b_first_rd", a_rd, 1);
    done_seen = 0;
    bad = 0;
    t = 0;
    while (done_seen < 3 && t < 500) begin
      if (a_tx_done === 1'b1) done_seen++;
      if (done_seen < 3 && a_busy !== 1'b1) bad++;
      if (done_seen == 3) chk("b2b_busy_falls", a_busy, 0);
      if (done_seen < 3) step();
      t++;
    end
    chk("b2b_done_pulses", done_seen, 3);
    chk("b2b_busy_gaps", bad, 0);
    step();
    step();
    chk("b2b_rd_count", a_rd_cnt, 4);
    chk("b2b_frames", a_frames, 4);
    chk("b2b_gap_count", a_gaps.size() - g_base, 3);
    if (a_gaps.size() >= g_base + 3) begin
      chk("b2b_mark_1_2", a_gaps[g_base + 1], 2);
      chk("b2b_mark_2_3", a_gaps[g_base + 2], 2);
    end

    // tx_en dropped in the middle of a frame
    push_a(8'hAA);
    push_a(8'h11);
    wait_a_cnt(12);
    a_tx_en = 1'b0;
    rd_base = a_rd_cnt;
    wait_a_done(5);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_tx !== 1'b1 || a_rd !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    chk("txen_hold_bad_cycles", bad, 0);
    chk("txen_no_more_rd", a_rd_cnt, rd_base);
    chk("txen_fifo_left", a_fifo.size(), 1);
    a_tx_en = 1'b1;
    wait_a_done(6);
    chk("txen_resume_frames", a_frames, 6);

    // Reset in the middle of bit 3 of 0x55
    step();
    push_a(8'h55);
    push_a(8'h0F);
    wait_a_cnt(4 * A_CPB + 1);
    reset = 1'b1;
    step();
    chk("midrst_tx", a_tx, 1);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_tx_done", a_tx_done, 0);
    reset = 1'b0;
    wait_a_done(7);
    step();
    chk("midrst_frames", a_frames, 7);
    chk("midrst_rd_count", a_rd_cnt, 8);

    // Latency sweep on instance B
    b_tx_en = 1'b1;
    push_b(8'h01);
    wait_b_done(1);
    step();
    chk("lat_b_rd_count", b_rd_cnt, 1);
    chk("lat_b_frames", b_frames, 1);
    chk("lat_b_busy_after", b_busy, 0);

    // Final bookkeeping
    step();
    chk("a_exp_empty", a_exp.size(), 0);
    chk("b_exp_empty", b_exp.size(), 0);
    chk("a_underflow", a_uflow, 0);
    chk("b_underflow", b_uflow, 0);
    chk("a_done_vs_frames", a_done_cnt, a_frames);
    chk("b_done_vs_frames", b_done_cnt, b_frames);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
